serial_nibble_framer: RTL and testbench
=======================================

Name: serial_nibble_framer

Overview:
Upstream front-end for the nibble pattern-detector FSM. It deframes a start/stop-framed serial bit stream into 4-bit nibbles and presents each nibble on a registered 4-bit bus that drives the detector's 4-bit input. A Moore FSM, advanced by a bit-sample strobe, handles framing. It also reports framing errors and keeps a saturating error count.

Parameters:
MSB_FIRST, 1, 1: first data bit received lands in nibble[3]; 0: first data bit lands in nibble[0]
HOLD_LAST, 1, 1: nibble holds the last good value between frames; 0: nibble returns to 4'b0000 one clock after nib_valid
CNT_W, 8, width of err_cnt

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
serial_in  input  1  serial line; idle level 1; start bit 0; stop bit 1
bit_en  input  1  sample strobe; serial_in is sampled only on clocks where bit_en=1
nibble  output  4  last correctly framed nibble, registered; feeds the downstream detector input
nib_valid  output  1  one-clock pulse, high in the cycle nibble takes a new value
frame_err  output  1  one-clock pulse on a bad stop bit
busy  output  1  high whenever state != IDLE
err_cnt  output  CNT_W  count of framing errors, saturating

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit_cnt=0, nibble=0, nib_valid=0, frame_err=0, err_cnt=0, busy=0. Asserting reset mid-frame aborts the frame and discards partial bits.
- All outputs are registered (Moore). No combinational path from inputs to outputs.
- bit_en=0: state, counters and shift register hold. serial_in is ignored. There is no timeout.
- bit_en=1 on every clock is legal: one bit per clock.
- FSM, evaluated only on clocks with bit_en=1:
  - IDLE: serial_in=0 -> DATA, bit_cnt<=0. serial_in=1 -> stay in IDLE.
  - DATA: shift in serial_in (position set by MSB_FIRST), bit_cnt++. After the 4th data bit (bit_cnt was 3) -> STOP.
  - STOP, serial_in=1: nibble<=assembled bits, nib_valid<=1 for the next cycle -> IDLE.
  - STOP, serial_in=0: frame_err<=1 for the next cycle, err_cnt++ (saturates at all-ones), nibble unchanged -> BREAK.
  - BREAK: serial_in=1 -> IDLE. serial_in=0 -> stay in BREAK.
  - Any illegal state encoding -> IDLE on the next clock, with no pulses.
- Latency: nib_valid rises after the clock edge that samples the stop bit and stays high for exactly one clock, even if bit_en stays low afterwards. frame_err follows the same timing.
- HOLD_LAST=1: nibble changes only on good frames.
- HOLD_LAST=0: nibble is cleared to 0 on the clock after nib_valid.
- Back-to-back frames: a start bit on the bit_en sample immediately after the stop bit is accepted. There is no idle gap requirement.
- nib_valid and frame_err are never high in the same cycle.

Test Plan:
1. MSB_FIRST=1, bit_en=1 continuous, serial_in 1,0,1,1,0,1,1 -> after the 7th edge: nibble=4'b1101, nib_valid high for 1 cycle, busy low; frame_err=0.
2. Two back-to-back 1101 frames, HOLD_LAST=1 -> nibble stays 4'b1101 throughout; exactly 2 nib_valid pulses 6 clocks apart.
3. Frame 0,1,0,1,0 then stop bit=0 -> frame_err pulses once; err_cnt=1; nibble keeps its previous value. Next, serial_in=0 for 3 samples -> stays in BREAK (busy=1). Then serial_in=1 -> IDLE.
4. bit_en pulsed every 3rd clock, MSB_FIRST=0, data bits 1,0,1,1 -> nibble=4'b1101. Outputs hold between strobes; nib_valid is still exactly 1 clock wide.
5. Assert reset=0 after 2 data bits, release, then send a full frame 0,0,1,1,0,1 -> all outputs 0 during reset; the new frame yields nibble=4'b0110 (MSB_FIRST=1) with no contamination from the aborted bits.
6. CNT_W=2, 5 bad-stop frames -> err_cnt reads 1,2,3,3,3; frame_err pulses 5 times.

Source files
------------

// File: rtl/serial_nibble_framer.sv
// serial_nibble_framer: deframes a start/stop-framed serial stream into registered
// 4-bit nibbles with framing-error pulse and saturating error count.
`default_nettype none

module serial_nibble_framer #(
  parameter bit MSB_FIRST = 1'b1,
  parameter bit HOLD_LAST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_en,
  output logic [3:0]       nibble,
  output logic             nib_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;
  localparam logic [1:0] ST_BREAK = 2'd3;

  logic [1:0] state, state_next;
  logic [3:0] shreg, shreg_next;
  logic [1:0] bit_cnt, bit_cnt_next;
  logic       load_nib;
  logic       flag_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      shreg   <= 4'b0000;
      bit_cnt <= 2'd0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    case (state)
      ST_IDLE: begin
        if (bit_en && !serial_in) begin
          state_next   = ST_DATA;
          bit_cnt_next = 2'd0;
          shreg_next   = 4'b0000;
        end
      end
      ST_DATA: begin
        if (bit_en) begin
          shreg_next   = MSB_FIRST ? {shreg[2:0], serial_in} : {serial_in, shreg[3:1]};
          bit_cnt_next = bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) begin
            state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (bit_en) begin
          state_next = serial_in ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (bit_en && serial_in) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    load_nib = 1'b0;
    flag_err = 1'b0;
    if (state == ST_STOP && bit_en) begin
      load_nib = serial_in;
      flag_err = !serial_in;
    end
  end

  // Pulses are cleared every clock, so they stay one cycle wide even with bit_en low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nibble    <= 4'b0000;
      nib_valid <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      nib_valid <= load_nib;
      frame_err <= flag_err;
      busy      <= (state_next != ST_IDLE);
      if (load_nib) begin
        nibble <= shreg;
      end else if (!HOLD_LAST && nib_valid) begin
        nibble <= 4'b0000;
      end
      if (flag_err && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_nibble_framer.sv
// Bench for serial_nibble_framer: three parameter variants share one stimulus stream
// and are checked every clock against a frame-level reference model.
`default_nettype none

module tb_serial_nibble_framer;

  logic clk = 1'b0;
  logic reset;
  logic serial_in;
  logic bit_en;

  logic [3:0] nib_a, nib_b, nib_c;
  logic       nv_a, nv_b, nv_c;
  logic       fe_a, fe_b, fe_c;
  logic       busy_a, busy_b, busy_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int vectors     = 0;
  int miscompares = 0;

  // frame-level reference model
  logic [3:0] m_nib_a = 4'h0, m_nib_b = 4'h0, m_nib_c = 4'h0;
  logic       m_valid = 1'b0, m_err = 1'b0, m_busy = 1'b0;
  logic [7:0] m_cnt8  = 8'd0;
  logic [1:0] m_cnt2  = 2'd0;

  int cyc = 0;
  int valid_count = 0, last_valid_cyc = 0, prev_valid_cyc = 0;
  int err_pulses_c = 0;

  localparam int K_FREE = 0;  // sample leaves the framer idle
  localparam int K_BUSY = 1;  // sample leaves the framer mid-frame or in break
  localparam int K_GOOD = 2;  // good stop bit
  localparam int K_BAD  = 3;  // bad stop bit

  always #5 clk = ~clk;

  serial_nibble_framer #(.MSB_FIRST(1'b1), .HOLD_LAST(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_en(bit_en),
    .nibble(nib_a), .nib_valid(nv_a), .frame_err(fe_a), .busy(busy_a), .err_cnt(cnt_a));

  serial_nibble_framer #(.MSB_FIRST(1'b0), .HOLD_LAST(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_en(bit_en),
    .nibble(nib_b), .nib_valid(nv_b), .frame_err(fe_b), .busy(busy_b), .err_cnt(cnt_b));

  serial_nibble_framer #(.MSB_FIRST(1'b1), .HOLD_LAST(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_en(bit_en),
    .nibble(nib_c), .nib_valid(nv_c), .frame_err(fe_c), .busy(busy_c), .err_cnt(cnt_c));

  // d holds the data bits in transmission order: d[3] is sent first.
  task automatic tick(input logic b, input logic en, input int kind, input logic [3:0] d);
    logic prev_valid;
    serial_in = b;
    bit_en    = en;
    @(posedge clk);
    #1;
    cyc++;
    prev_valid = m_valid;
    m_valid    = 1'b0;
    m_err      = 1'b0;
    if (prev_valid) m_nib_b = 4'h0;
    if (en) begin
      case (kind)
        K_FREE: m_busy = 1'b0;
        K_BUSY: m_busy = 1'b1;
        K_GOOD: begin
          m_busy  = 1'b0;
          m_valid = 1'b1;
          m_nib_a = d;
          m_nib_c = d;
          m_nib_b = {d[0], d[1], d[2], d[3]};
        end
        K_BAD: begin
          m_busy = 1'b1;
          m_err  = 1'b1;
          if (m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
          if (m_cnt2 != 2'd3)  m_cnt2 = m_cnt2 + 2'd1;
        end
        default: ;
      endcase
    end
    if (nv_a) begin
      valid_count++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (fe_c) err_pulses_c++;
    vectors++;
    if ({nib_a, nv_a, fe_a, busy_a, cnt_a} !== {m_nib_a, m_valid, m_err, m_busy, m_cnt8}) begin
      miscompares++;
      $display("FAIL dut_a {nib,valid,err,busy,cnt} cyc=%0d got=%h_%b%b%b_%h exp=%h_%b%b%b_%h", cyc,
               nib_a, nv_a, fe_a, busy_a, cnt_a, m_nib_a, m_valid, m_err, m_busy, m_cnt8);
    end
    vectors++;
    if ({nib_b, nv_b, fe_b, busy_b, cnt_b} !== {m_nib_b, m_valid, m_err, m_busy, m_cnt8}) begin
      miscompares++;
      $display("FAIL dut_b {nib,valid,err,busy,cnt} cyc=%0d got=%h_%b%b%b_%h exp=%h_%b%b%b_%h", cyc,
               nib_b, nv_b, fe_b, busy_b, cnt_b, m_nib_b, m_valid, m_err, m_busy, m_cnt8);
    end
    vectors++;
    if ({nib_c, nv_c, fe_c, busy_c, cnt_c} !== {m_nib_c, m_valid, m_err, m_busy, m_cnt2}) begin
      miscompares++;
      $display("FAIL dut_c {nib,valid,err,busy,cnt} cyc=%0d got=%h_%b%b%b_%h exp=%h_%b%b%b_%h", cyc,
               nib_c, nv_c, fe_c, busy_c, cnt_c, m_nib_c, m_valid, m_err, m_busy, m_cnt2);
    end
  endtask

  task automatic send_bit(input logic b, input int kind, input logic [3:0] d,
                          input int gmin, input int gmax);
    int gap;
    gap = $urandom_range(gmax, gmin);
    repeat (gap) tick(1'($urandom_range(1, 0)), 1'b0, K_FREE, d);
    tick(b, 1'b1, kind, d);
  endtask

  task automatic send_frame(input logic [3:0] d, input bit good, input int brk,
                            input int idle, input int gmin, input int gmax);
    repeat (idle) send_bit(1'b1, K_FREE, d, gmin, gmax);
    send_bit(1'b0, K_BUSY, d, gmin, gmax);
    for (int i = 3; i >= 0; i--) send_bit(d[i], K_BUSY, d, gmin, gmax);
    if (good) begin
      send_bit(1'b1, K_GOOD, d, gmin, gmax);
    end else begin
      send_bit(1'b0, K_BAD, d, gmin, gmax);
      repeat (brk) send_bit(1'b0, K_BUSY, d, gmin, gmax);
      send_bit(1'b1, K_FREE, d, gmin, gmax);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    serial_in = 1'b0;
    bit_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({nib_a, nv_a, fe_a, busy_a, cnt_a, nib_b, nv_b, fe_b, busy_b, cnt_b,
         nib_c, nv_c, fe_c, busy_c, cnt_c} !== 43'd0) begin
      miscompares++;
      $display("FAIL reset_state got a=%h/%b%b%b/%h b=%h/%b%b%b/%h c=%h/%b%b%b/%h exp all zero",
               nib_a, nv_a, fe_a, busy_a, cnt_a, nib_b, nv_b, fe_b, busy_b, cnt_b,
               nib_c, nv_c, fe_c, busy_c, cnt_c);
    end
    bit_en = 1'b0;
    reset  = 1'b1;
    tick(1'b1, 1'b1, K_FREE, 4'h0);
  endtask

  task automatic test_basic();
    send_frame(4'b1101, 1'b1, 0, 1, 0, 0);
    vectors++;
    if ({nib_a, nv_a, busy_a, fe_a} !== {4'b1101, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_frame got nib=%b valid=%b busy=%b err=%b exp nib=1101 valid=1 busy=0 err=0",
               nib_a, nv_a, busy_a, fe_a);
    end
    tick(1'b1, 1'b1, K_FREE, 4'h0);
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_count;
    send_frame(4'b1101, 1'b1, 0, 0, 0, 0);
    send_frame(4'b1101, 1'b1, 0, 0, 0, 0);
    tick(1'b1, 1'b1, K_FREE, 4'h0);
    vectors++;
    if (valid_count - v0 != 2 || last_valid_cyc - prev_valid_cyc != 6) begin
      miscompares++;
      $display("FAIL back_to_back got pulses=%0d spacing=%0d exp pulses=2 spacing=6",
               valid_count - v0, last_valid_cyc - prev_valid_cyc);
    end
  endtask

  task automatic test_bad_stop();
    send_bit(1'b0, K_BUSY, 4'b1010, 0, 0);
    for (int i = 3; i >= 0; i--) send_bit(i[0] ? 1'b1 : 1'b0, K_BUSY, 4'b1010, 0, 0);
    send_bit(1'b0, K_BAD, 4'b1010, 0, 0);
    vectors++;
    if ({fe_a, nv_a, cnt_a, nib_a} !== {1'b1, 1'b0, 8'd1, 4'b1101}) begin
      miscompares++;
      $display("FAIL bad_stop got err=%b valid=%b cnt=%0d nib=%b exp err=1 valid=0 cnt=1 nib=1101",
               fe_a, nv_a, cnt_a, nib_a);
    end
    repeat (3) send_bit(1'b0, K_BUSY, 4'h0, 0, 0);
    vectors++;
    if (busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL break_hold got busy=%b exp busy=1", busy_a);
    end
    send_bit(1'b1, K_FREE, 4'h0, 0, 0);
  endtask

  task automatic test_strobe_gaps();
    send_frame(4'b1011, 1'b1, 0, 1, 2, 2);
    vectors++;
    if ({nib_b, nv_b} !== {4'b1101, 1'b1}) begin
      miscompares++;
      $display("FAIL lsb_first_gapped got nib=%b valid=%b exp nib=1101 valid=1", nib_b, nv_b);
    end
    repeat (3) tick(1'b0, 1'b0, K_FREE, 4'h0);
  endtask

  task automatic test_reset_midframe();
    send_bit(1'b0, K_BUSY, 4'h0, 0, 0);
    send_bit(1'b1, K_BUSY, 4'h0, 0, 0);
    send_bit(1'b1, K_BUSY, 4'h0, 0, 0);
    bit_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    m_nib_a = 4'h0; m_nib_b = 4'h0; m_nib_c = 4'h0;
    m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    m_cnt8  = 8'd0; m_cnt2 = 2'd0;
    vectors++;
    if ({nib_a, nv_a, fe_a, busy_a, cnt_a, nib_c, cnt_c} !== 25'd0) begin
      miscompares++;
      $display("FAIL async_reset got nib=%b busy=%b cnt=%0d nib_c=%b cnt_c=%0d exp all zero",
               nib_a, busy_a, cnt_a, nib_c, cnt_c);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    send_frame(4'b0110, 1'b1, 0, 0, 0, 0);
    vectors++;
    if ({nib_a, nv_a} !== {4'b0110, 1'b1}) begin
      miscompares++;
      $display("FAIL post_reset_frame got nib=%b valid=%b exp nib=0110 valid=1", nib_a, nv_a);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_seq [5];
    int p0;
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    p0 = err_pulses_c;
    for (int k = 0; k < 5; k++) begin
      send_frame(4'($urandom_range(15, 0)), 1'b0, 0, 1, 0, 0);
      vectors++;
      if (cnt_c !== exp_seq[k]) begin
        miscompares++;
        $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, cnt_c, exp_seq[k]);
      end
    end
    vectors++;
    if (err_pulses_c - p0 != 5) begin
      miscompares++;
      $display("FAIL sat_pulses got=%0d exp=5", err_pulses_c - p0);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      send_frame(4'($urandom_range(15, 0)), ($urandom_range(3, 0) != 0),
                 $urandom_range(3, 0), $urandom_range(2, 0), 0, 2);
    end
    repeat (4) tick(1'b1, 1'b0, K_FREE, 4'h0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_bad_stop();
    test_strobe_gaps();
    test_reset_midframe();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
